// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU control unit: state encoding,
// instruction field positions and datapath widths.
package hack_pkg;

  localparam int unsigned AddrW = 15;
  localparam int unsigned DataW = 16;

  localparam int unsigned IR_CINST   = 15;
  localparam int unsigned IR_A       = 12;
  localparam int unsigned IR_COMP_HI = 11;
  localparam int unsigned IR_COMP_LO = 6;
  localparam int unsigned IR_DEST_A  = 5;
  localparam int unsigned IR_DEST_D  = 4;
  localparam int unsigned IR_DEST_M  = 3;
  localparam int unsigned IR_JLT     = 2;
  localparam int unsigned IR_JEQ     = 1;
  localparam int unsigned IR_JGT     = 0;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StMemRd,
    StExec,
    StMemWr,
    StCommit,
    StHalted
  } state_e;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational jump resolution from the lt/eq/gt jump bits and the latched
// ALU zero/negative flags.
module hack_jump_cond (
  input  logic [2:0] jump_i,
  input  logic       zr_i,
  input  logic       ng_i,
  output logic       take_o
);

  // jump_i = {lt, eq, gt}
  always_comb begin
    take_o = (jump_i[2] & ng_i) | (jump_i[1] & zr_i) | (jump_i[0] & ~zr_i & ~ng_i);
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control unit driving an external combinational ALU.
// Optional self-loop halt detection is enabled by defining HACK_HALT_DETECT_EN.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter logic [14:0] RESET_PC = 15'd0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [AddrW-1:0]  imem_addr,
  input  logic              imem_ack,
  input  logic [DataW-1:0]  imem_data,
  output logic              dmem_rd,
  output logic              dmem_wr,
  output logic [AddrW-1:0]  dmem_addr,
  output logic [DataW-1:0]  dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DataW-1:0]  dmem_rdata,
  output logic [DataW-1:0]  alu_x,
  output logic [DataW-1:0]  alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [DataW-1:0]  alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [AddrW-1:0]  pc,
  output logic              halt
);

  localparam logic [AddrW-1:0] PcOne = 15'd1;

  state_e           state_q, state_d;
  logic [AddrW-1:0] pc_q, pc_d;
  logic [DataW-1:0] a_q, a_d;
  logic [DataW-1:0] d_q, d_d;
  logic [DataW-1:0] ir_q, ir_d;
  logic [DataW-1:0] mdr_q, mdr_d;
  logic [DataW-1:0] r_q, r_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             imem_req_q, imem_req_d;
  logic             dmem_rd_q, dmem_rd_d;
  logic             dmem_wr_q, dmem_wr_d;
  logic             take;
  logic [AddrW-1:0] pc_inc;

  hack_jump_cond u_jump_cond (
    .jump_i ({ir_q[IR_JLT], ir_q[IR_JEQ], ir_q[IR_JGT]}),
    .zr_i   (zr_q),
    .ng_i   (ng_q),
    .take_o (take)
  );

  assign pc_inc = pc_q + PcOne;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      a_q        <= '0;
      d_q        <= '0;
      ir_q       <= '0;
      mdr_q      <= '0;
      r_q        <= '0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_rd_q  <= 1'b0;
      dmem_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      a_q        <= a_d;
      d_q        <= d_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      r_q        <= r_d;
      zr_q       <= zr_d;
      ng_q       <= ng_d;
      imem_req_q <= imem_req_d;
      dmem_rd_q  <= dmem_rd_d;
      dmem_wr_q  <= dmem_wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    r_d     = r_q;
    zr_d    = zr_q;
    ng_d    = ng_q;

    case (state_q)
      StFetch: begin
        // An ack with no request outstanding is ignored.
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!ir_q[IR_CINST]) begin
          a_d     = ir_q;
          pc_d    = pc_inc;
          state_d = StFetch;
        end else begin
          state_d = ir_q[IR_A] ? StMemRd : StExec;
        end
      end
      StMemRd: begin
        if (dmem_rd_q && dmem_ack) begin
          mdr_d   = dmem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        r_d     = alu_out;
        zr_d    = alu_zr;
        ng_d    = alu_ng;
        state_d = ir_q[IR_DEST_M] ? StMemWr : StCommit;
      end
      StMemWr: begin
        if (dmem_wr_q && dmem_ack) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        // a_q still holds the pre-instruction A, so it is the jump target.
        pc_d = take ? a_q[AddrW-1:0] : pc_inc;
        if (ir_q[IR_DEST_A]) a_d = r_q;
        if (ir_q[IR_DEST_D]) d_d = r_q;
        state_d = StFetch;
`ifdef HACK_HALT_DETECT_EN
        if (take && (a_q[AddrW-1:0] == pc_q)) begin
          state_d = StHalted;
        end
`endif
      end
`ifdef HACK_HALT_DETECT_EN
      StHalted: state_d = StHalted;
`endif
      default: state_d = StFetch;
    endcase

    // Requests are registered so they rise on the state-entry edge.
    imem_req_d = (state_d == StFetch);
    dmem_rd_d  = (state_d == StMemRd);
    dmem_wr_d  = (state_d == StMemWr);
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_rd    = dmem_rd_q;
  assign dmem_wr    = dmem_wr_q;
  assign dmem_addr  = a_q[AddrW-1:0];
  assign dmem_wdata = r_q;
  assign pc         = pc_q;

  assign alu_x = d_q;
  assign alu_y = ir_q[IR_A] ? mdr_q : a_q;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_q[IR_COMP_HI:IR_COMP_LO];

`ifdef HACK_HALT_DETECT_EN
  assign halt = (state_q == StHalted) & ~reset;
`else
  assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Scoreboard bench for hack_cpu_ctrl: an ISA-level model predicts PC/A/D,
// data-memory transfers and cycle counts; a behavioural ALU and memories respond.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [14:0] imem_addr;
  logic [15:0] imem_data;
  logic        dmem_rd, dmem_wr, dmem_ack;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
  logic [14:0] pc;
  logic        halt;

  hack_cpu_ctrl #(.RESET_PC(15'd0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
    .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc(pc), .halt(halt)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] alu_model(input logic [15:0] x_in, input logic [15:0] y_in,
                                            input logic [5:0] c);
    logic [15:0] x, y, o;
    x = x_in;
    y = y_in;
    if (c[5]) x = 16'h0;
    if (c[4]) x = ~x;
    if (c[3]) y = 16'h0;
    if (c[2]) y = ~y;
    o = c[1] ? (x + y) : (x & y);
    if (c[0]) o = ~o;
    return {(o == 16'h0), o[15], o};
  endfunction

  assign {alu_zr, alu_ng, alu_out} =
    alu_model(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {logic wr; logic [14:0] addr; logic [15:0] data;} dm_exp_t;
  typedef struct {logic [14:0] pc; logic [15:0] a; logic [15:0] d;} st_exp_t;

  dm_exp_t     exp_dm[$];
  st_exp_t     exp_st[$];
  logic [15:0] dm_mem [0:32767];
  int          dm_wait = 0;

  logic [14:0] mpc;
  logic [15:0] ma, md;
  bit          mhalt;

  // Data memory responder: ack after dm_wait stalled request cycles.
  initial begin
    int      cnt;
    dm_exp_t e;
    cnt        = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (reset || !(dmem_rd || dmem_wr)) begin
        cnt = 0;
      end else if (cnt < dm_wait) begin
        cnt++;
      end else begin
        cnt      = 0;
        dmem_ack = 1'b1;
        if (exp_dm.size() == 0) begin
          check_eq("dm_unexpected", {dmem_wr, dmem_rd}, 0);
        end else begin
          e = exp_dm.pop_front();
          check_eq("dm_dir", {dmem_wr, dmem_rd}, {e.wr, ~e.wr});
          check_eq("dm_addr", dmem_addr, e.addr);
          if (e.wr) begin
            check_eq("dm_wdata", dmem_wdata, e.data);
            dm_mem[dmem_addr] = dmem_wdata;
          end else begin
            dmem_rdata = dm_mem[dmem_addr];
          end
        end
      end
    end
  end

  task automatic check_state();
    st_exp_t e;
    if (exp_st.size() != 0) begin
      e = exp_st.pop_front();
      check_eq("pc", pc, e.pc);
      check_eq("imem_addr", imem_addr, e.pc);
      check_eq("a_reg", dmem_addr, e.a[14:0]);
      check_eq("d_reg", alu_x, e.d);
    end
    check_eq("dm_pending", exp_dm.size(), 0);
  endtask

  task automatic wait_req(input string tag);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (imem_req) break;
    end
    check_eq(tag, imem_req, 1);
  endtask

  // Entered at a negedge with imem_req high; leaves at the next fetch.
  task automatic exec_instr(input logic [15:0] instr, input int iw);
    logic [15:0] y, out;
    logic        zr, ng, take;
    int          lat, n;
    for (int k = 0; k < iw; k++) begin
      @(negedge clk);
      check_eq("imem_hold", {imem_req, imem_addr}, {1'b1, mpc});
    end
    imem_ack  = 1'b1;
    imem_data = instr;
    y         = 16'h0;
    if (!instr[15]) begin
      lat = 2;
      ma  = instr;
      mpc = mpc + 15'd1;
      exp_st.push_back('{mpc, ma, md});
    end else begin
      y = instr[12] ? dm_mem[ma[14:0]] : ma;
      {zr, ng, out} = alu_model(md, y, instr[11:6]);
      lat = 4;
      if (instr[12]) begin
        lat += 1 + dm_wait;
        exp_dm.push_back('{1'b0, ma[14:0], 16'h0});
      end
      if (instr[3]) begin
        lat += 1 + dm_wait;
        exp_dm.push_back('{1'b1, ma[14:0], out});
      end
      take = (instr[2] && $signed(out) < 0) || (instr[1] && out == 16'h0) ||
             (instr[0] && $signed(out) > 0);
`ifdef HACK_HALT_DETECT_EN
      if (take && ma[14:0] == mpc) mhalt = 1'b1;
`endif
      mpc = take ? ma[14:0] : mpc + 15'd1;
      if (instr[5]) ma = out;
      if (instr[4]) md = out;
      if (!mhalt) exp_st.push_back('{mpc, ma, md});
    end
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        imem_ack  = 1'b0;
        imem_data = 16'h0;
      end
      if (k == 2 && instr[15] && !instr[12]) begin
        check_eq("alu_ctl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, instr[11:6]);
        check_eq("alu_y", alu_y, y);
      end
      if (imem_req) begin
        n = k;
        break;
      end
      if (mhalt && k == 20) break;
    end
    if (mhalt) begin
      check_eq("halt", halt, 1);
      check_eq("halt_noreq", imem_req, 0);
    end else begin
      check_eq("latency", n, lat);
      check_state();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_reqs", {imem_req, dmem_rd, dmem_wr}, 3'b000);
    check_eq("rst_halt", halt, 0);
    check_eq("rst_pc", pc, 15'd0);
    check_eq("rst_alu_ctl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 6'd0);
    exp_dm.delete();
    exp_st.delete();
    mpc   = 15'd0;
    ma    = 16'h0;
    md    = 16'h0;
    mhalt = 1'b0;
    exp_st.push_back('{mpc, ma, md});
    reset = 1'b0;
    wait_req("req_after_rst");
    check_state();
  endtask

  initial begin
    reset     = 1'b1;
    imem_ack  = 1'b0;
    imem_data = 16'h0;
    mpc       = 15'd0;
    ma        = 16'h0;
    md        = 16'h0;
    mhalt     = 1'b0;
    repeat (3) @(negedge clk);
    apply_reset();

    exec_instr(16'h0005, 0);
    exec_instr(16'h0007, 1);
    exec_instr(16'hEC10, 0);              // D=A
    exec_instr(16'h0064, 0);
    dm_wait = 3;
    exec_instr(16'hE7C8, 0);              // M=D+1
    dm_mem[100] = 16'h1234;
    dm_wait = 2;
    exec_instr(16'hFC10, 0);              // D=M
    dm_wait = 0;
    exec_instr(16'hEE90, 0);              // D=-1
    exec_instr(16'h000A, 0);
    exec_instr(16'hE304, 0);              // D;JLT taken
    exec_instr(16'hEFD0, 0);              // D=1
    exec_instr(16'h000A, 0);
    exec_instr(16'hE304, 2);              // D;JLT not taken
    exec_instr(16'h00C8, 0);
    exec_instr(16'hE7E8, 0);              // AM=D+1 writes at old A
    exec_instr(16'h7FFF, 0);
    exec_instr(16'hEA87, 0);              // jump to 0x7FFF
    exec_instr(16'h0005, 0);              // PC wraps to 0
    exec_instr(16'h0001, 0);
    exec_instr(16'hEA87, 0);              // self-loop

    if (!mhalt) begin
      // Abandon a stalled write with reset.
      exec_instr(16'h00C8, 0);
      dm_wait   = 10;
      imem_ack  = 1'b1;
      imem_data = 16'hE7C8;
      @(negedge clk);
      imem_ack = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (dmem_wr) break;
        @(negedge clk);
      end
      check_eq("wr_pending", dmem_wr, 1);
    end
    apply_reset();
    dm_wait = 0;
    exec_instr(16'h0005, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle Hack CPU control unit that issues operations to the 16-bit Hack ALU. It fetches instructions over a req/ack instruction port and decodes A- and C-instructions. It drives the ALU operands (x, y) and the control bits (zx, nx, zy, ny, f, no), then consumes out/zr/ng to write back A, D and memory and to resolve jumps. It sits between instruction/data memory and the combinational ALU, and owns the A, D, PC and IR registers.

## Interface
Parameters:
- RESET_PC, 15'd0, PC value loaded on reset

Ports:
- clk  in  1  system clock; single clock domain, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  15  fetch address (= PC)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  16  instruction word
- dmem_rd  out  1  data read request
- dmem_wr  out  1  data write request
- dmem_addr  out  15  data address (= A[14:0])
- dmem_wdata  out  16  write data
- dmem_ack  in  1  data transfer complete; dmem_rdata valid on reads
- dmem_rdata  in  16  read data (M)
- alu_x  out  16  ALU x operand (= D)
- alu_y  out  16  ALU y operand (A when IR[12]=0, MDR when IR[12]=1)
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  = IR[11], IR[10], IR[9], IR[8], IR[7], IR[6]
- alu_out  in  16  ALU result
- alu_zr  in  1  result zero
- alu_ng  in  1  result negative
- pc  out  15  current PC
- halt  out  1  self-loop detected (see Configuration)

## Operation
- Instruction fields:
  - IR[15]=0: A-instruction; A←IR.
  - IR[15]=1: C-instruction. a=IR[12], comp=IR[11:6], dest A/D/M = IR[5]/IR[4]/IR[3], jump lt/eq/gt = IR[2]/IR[1]/IR[0].
- FSM states: FETCH, DECODE, MEM_RD, EXEC, MEM_WR, COMMIT, HALTED.
  - FETCH: imem_req=1, imem_addr=PC. On imem_ack: IR←imem_data, go to DECODE.
  - DECODE: for an A-instruction, A←IR and PC←PC+1, go to FETCH. For a C-instruction, go to MEM_RD if a=1, else EXEC.
  - MEM_RD: dmem_rd=1, dmem_addr=A. On dmem_ack: MDR←dmem_rdata, go to EXEC.
  - EXEC: R←alu_out, ZR←alu_zr, NG←alu_ng. Go to MEM_WR if dest M, else COMMIT.
  - MEM_WR: dmem_wr=1, dmem_addr=A, dmem_wdata=R. Hold until dmem_ack, then go to COMMIT.
  - COMMIT:
    - take = (IR[2]&NG) | (IR[1]&ZR) | (IR[0]&~ZR&~NG).
    - PC←take ? A[14:0] (pre-instruction A) : PC+1.
    - A←R if dest A; D←R if dest D.
    - Go to FETCH.
- Memory address and jump target always use the A value from before the instruction. A simultaneous A and M destination writes M at the old A.
- PC+1 wraps modulo 2^15 (0x7FFF→0x0000).
- Handshake:
  - req/rd/wr assert at the state entry edge and stay high with stable address/data until the ack cycle, inclusive.
  - Each request deasserts on the edge that samples ack.
  - ack arriving with no request pending is ignored.
- alu_* outputs are combinational from IR/A/D/MDR and valid in every state; they are sampled only in EXEC.

## Timing
- Reset values: PC=RESET_PC; A=D=IR=MDR=R=0; state FETCH. imem_req, dmem_rd, dmem_wr and halt are 0 while reset is high; all alu_* controls are 0.
- imem_req rises in the first cycle after reset deasserts.
- Cycles with zero-wait acks (ack high in the first request cycle):
  - A-instruction: 2.
  - C-instruction, no memory access: 4.
  - Add 1 cycle each for MEM_RD and MEM_WR, plus 1 cycle per wait cycle.
- Reset asserted mid-transaction: request outputs drop on the next edge, and the outstanding transaction is abandoned. No A/D/PC update is taken from it.

## Configuration
- HACK_HALT_DETECT_EN defined:
  - In COMMIT, a taken jump with A[14:0]==PC enters HALTED.
  - In HALTED, halt=1, no requests are issued, and registers are frozen until reset.
- HACK_HALT_DETECT_EN undefined: no HALTED state, halt tied to 0, and self-loops keep fetching.

## Structure
- Package hack_pkg:
  - state enum.
  - Instruction bit-position constants: IR_CINST=15, IR_A=12, comp range, dest bits, jump bits.
  - PC/address width constant 15 and data width constant 16.
- Sub-module hack_jump_cond: combinational take = f(jump bits, zr, ng). Reusable by a future pipelined core.

## Test plan
- Fetch 0x0005 at PC 0 -> A=0x0005, PC=1, next imem_req in the 3rd cycle (2-cycle A-instruction).
- @7 then 0xEC10 (D=A) -> during EXEC, alu_zx..alu_no=110000 and alu_y=7; then D=7, no dmem activity.
- D=7, @100, 0xE7C8 (M=D+1) -> dmem_wr with addr 100, wdata 0x0008, held across 3 wait cycles until ack; A stays 100.
- A=100, 0xFC10 (D=M), dmem_rdata=0x1234 after 2 wait cycles -> dmem_rd addr 100, then D=0x1234.
- D=0xFFFF, @10, 0xE304 (D;JLT) -> PC=10. Same with D=0x0001 -> PC=old PC+1.
- Macro on: @3 at PC 2, 0xEA87 (0;JMP) at PC 3 -> halt=1, imem_req stays 0. Reset pulse -> PC=RESET_PC, halt=0.
